// File: rtl/regfile_pkg.sv
// Shared constants and types for the 32-entry register file.
package regfile_pkg;
  localparam int NUM_REGS         = 32;
  localparam int REG_IDX_W        = 5;
  localparam int DATA_W_DEFAULT   = 64;
  localparam int ZERO_REG_DEFAULT = 31;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
endpackage

// File: rtl/regfile_if.sv
// Write port and two read ports of the register file, grouped as one bus.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
);
  // No handshake: a write is presented for one cycle with RegWrite=1 and is
  // committed at the next rising clk edge; read data follows the indices
  // combinationally in the same cycle.
  logic              RegWrite;
  reg_idx_t          WriteRegister;
  logic [DATA_W-1:0] WriteData;
  reg_idx_t          ReadRegister1;
  reg_idx_t          ReadRegister2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;

  modport master (
    output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    input  ReadData1, ReadData2
  );

  modport slave (
    input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    output ReadData1, ReadData2
  );
endinterface

// File: rtl/regfile_decoder5_32.sv
// 5-bit index to 32-bit one-hot write-enable decoder, all zeros when disabled.
module decoder5_32
  import regfile_pkg::*;
(
  input  reg_idx_t            i_idx,
  input  logic                i_en,
  output logic [NUM_REGS-1:0] o_onehot
);
  // Enable is ANDed first so an unknown index cannot leak into any output.
  always_comb begin
    o_onehot = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      o_onehot[k] = i_en && (i_idx == reg_idx_t'(k));
    end
  end
endmodule

// File: rtl/regfile_mux32_1.sv
// Single-bit 32:1 select cell, built as a five-level 2:1 mux tree.
module mux32_1 (
  input  logic [31:0] i_d,
  input  logic [4:0]  i_sel,
  output logic        o_y
);
  logic [15:0] w_l1;
  logic [7:0]  w_l2;
  logic [3:0]  w_l3;
  logic [1:0]  w_l4;

  for (genvar k = 0; k < 16; k++) begin : g_l1
    assign w_l1[k] = i_sel[0] ? i_d[2*k+1] : i_d[2*k];
  end
  for (genvar k = 0; k < 8; k++) begin : g_l2
    assign w_l2[k] = i_sel[1] ? w_l1[2*k+1] : w_l1[2*k];
  end
  for (genvar k = 0; k < 4; k++) begin : g_l3
    assign w_l3[k] = i_sel[2] ? w_l2[2*k+1] : w_l2[2*k];
  end
  for (genvar k = 0; k < 2; k++) begin : g_l4
    assign w_l4[k] = i_sel[3] ? w_l3[2*k+1] : w_l3[2*k];
  end

  assign o_y = i_sel[4] ? w_l4[1] : w_l4[0];
endmodule

// File: rtl/regfile.sv
// 32 x DATA_W register file, one write port and two combinational read ports.
// Optional write-through bypass on the read ports: define REGFILE_BYPASS_EN.
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int ZERO_REG = ZERO_REG_DEFAULT
)(
  input  logic     clk,
  input  logic     reset,
  regfile_if.slave rf_bus
);
  localparam reg_idx_t ZERO_IDX = reg_idx_t'(ZERO_REG);

  logic                w_wr_en;
  logic [NUM_REGS-1:0] w_we_oh;
  logic [DATA_W-1:0]   w_q [NUM_REGS];
  logic [DATA_W-1:0][NUM_REGS-1:0] w_slice;
  logic [DATA_W-1:0]   w_rd1;
  logic [DATA_W-1:0]   w_rd2;

  // Zero-register writes are dropped before decode, so its enable never fires.
  assign w_wr_en = rf_bus.RegWrite && (rf_bus.WriteRegister != ZERO_IDX);

  decoder5_32 u_dec (
    .i_idx    (rf_bus.WriteRegister),
    .i_en     (w_wr_en),
    .o_onehot (w_we_oh)
  );

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    if (r == ZERO_REG) begin : g_zero
      logic w_unused_we;
      assign w_unused_we = w_we_oh[r];
      assign w_q[r]      = '0;
    end else begin : g_store
      logic [DATA_W-1:0] r_q;
      always_ff @(posedge clk) begin
        if (!reset) begin
          r_q <= '0;
        end else if (w_we_oh[r]) begin
          r_q <= rf_bus.WriteData;
        end
      end
      assign w_q[r] = r_q;
    end
  end

  // Transpose storage so slice b gathers bit b of every register.
  for (genvar b = 0; b < DATA_W; b++) begin : g_slice
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_bit
      assign w_slice[b][r] = w_q[r][b];
    end

    mux32_1 u_mux_rd1 (
      .i_d   (w_slice[b]),
      .i_sel (rf_bus.ReadRegister1),
      .o_y   (w_rd1[b])
    );

    mux32_1 u_mux_rd2 (
      .i_d   (w_slice[b]),
      .i_sel (rf_bus.ReadRegister2),
      .o_y   (w_rd2[b])
    );
  end

`ifdef REGFILE_BYPASS_EN
  logic w_byp1;
  logic w_byp2;

  // Forward the in-flight write so a WB->ID read in the same cycle sees it.
  assign w_byp1 = reset && w_wr_en && (rf_bus.WriteRegister == rf_bus.ReadRegister1);
  assign w_byp2 = reset && w_wr_en && (rf_bus.WriteRegister == rf_bus.ReadRegister2);

  assign rf_bus.ReadData1 = w_byp1 ? rf_bus.WriteData : w_rd1;
  assign rf_bus.ReadData2 = w_byp2 ? rf_bus.WriteData : w_rd2;
`else
  assign rf_bus.ReadData1 = w_rd1;
  assign rf_bus.ReadData2 = w_rd2;
`endif
endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile against an array-based reference model.
module tb_regfile;
  localparam int DW = 64;

  logic clk;
  logic rst_n;

  regfile_if #(.DATA_W(DW)) bus ();

  regfile #(.DATA_W(DW), .ZERO_REG(31)) dut (
    .clk    (clk),
    .reset  (rst_n),
    .rf_bus (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural register contents as a plain array.
  logic [DW-1:0] model [32];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [DW-1:0] exp_read(input logic [4:0] idx);
    logic [DW-1:0] v;
    v = (idx == 5'd31) ? '0 : model[idx];
`ifdef REGFILE_BYPASS_EN
    if (rst_n && bus.RegWrite && bus.WriteRegister == idx && idx != 5'd31)
      v = bus.WriteData;
`endif
    return v;
  endfunction

  // Driver tasks
  task automatic drive(input logic we, input logic [4:0] wr, input logic [DW-1:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2);
    bus.RegWrite      = we;
    bus.WriteRegister = wr;
    bus.WriteData     = wd;
    bus.ReadRegister1 = r1;
    bus.ReadRegister2 = r2;
  endtask

  // Commit one rising edge into the model, then return at the falling edge.
  task automatic tick();
    logic          we;
    logic          rn;
    logic [4:0]    wr;
    logic [DW-1:0] wd;
    we = bus.RegWrite;
    rn = rst_n;
    wr = bus.WriteRegister;
    wd = bus.WriteData;
    @(posedge clk);
    if (!rn) begin
      for (int i = 0; i < 32; i++) model[i] = '0;
    end else if (we === 1'b1 && wr != 5'd31) begin
      model[wr] = wd;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 5'd12, 64'hFFFF_0000_FFFF_0000, 5'd0, 5'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, '0, 5'(i), 5'(31 - i));
      #1;
      n_checks++;
      if (bus.ReadData1 !== 64'h0)
        $display("FAIL reset_rd1 idx=%0d: got %h expected 0", i, bus.ReadData1);
      else n_pass++;
      n_checks++;
      if (bus.ReadData2 !== 64'h0)
        $display("FAIL reset_rd2 idx=%0d: got %h expected 0", 31 - i, bus.ReadData2);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_write_readback();
    drive(1'b1, 5'd5, 64'h0123_4567_89AB_CDEF, 5'd0, 5'd0);
    tick();
    drive(1'b1, 5'd30, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 5'd0);
    tick();
    drive(1'b0, 5'd0, '0, 5'd5, 5'd30);
    #1;
    n_checks++;
    if (bus.ReadData1 !== 64'h0123_4567_89AB_CDEF)
      $display("FAIL readback_x5: got %h expected %h", bus.ReadData1, 64'h0123_4567_89AB_CDEF);
    else n_pass++;
    n_checks++;
    if (bus.ReadData2 !== 64'hFFFF_FFFF_FFFF_FFFF)
      $display("FAIL readback_x30: got %h expected %h", bus.ReadData2, 64'hFFFF_FFFF_FFFF_FFFF);
    else n_pass++;
    @(negedge clk);
    drive(1'b0, 5'd0, '0, 5'd4, 5'd6);
    #1;
    n_checks++;
    if (bus.ReadData1 !== 64'h0) $display("FAIL readback_x4: got %h expected 0", bus.ReadData1);
    else n_pass++;
    n_checks++;
    if (bus.ReadData2 !== 64'h0) $display("FAIL readback_x6: got %h expected 0", bus.ReadData2);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_zero_reg();
    drive(1'b1, 5'd31, 64'h0000_0000_DEAD_BEEF, 5'd31, 5'd31);
    #1;
    n_checks++;
    if (bus.ReadData1 !== 64'h0) $display("FAIL zero_same_cycle: got %h expected 0", bus.ReadData1);
    else n_pass++;
    tick();
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 5'(c + 10), {$urandom, $urandom}, 5'd31, 5'd31);
      #1;
      n_checks++;
      if (bus.ReadData1 !== 64'h0) $display("FAIL zero_rd1 cyc=%0d: got %h expected 0", c, bus.ReadData1);
      else n_pass++;
      n_checks++;
      if (bus.ReadData2 !== 64'h0) $display("FAIL zero_rd2 cyc=%0d: got %h expected 0", c, bus.ReadData2);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_write_disabled();
    drive(1'b0, 5'd7, 64'hA5A5, 5'd7, 5'd7);
    tick();
    drive(1'b0, 5'd0, '0, 5'd7, 5'd7);
    #1;
    n_checks++;
    if (bus.ReadData1 !== 64'h0) $display("FAIL disabled_x7: got %h expected 0", bus.ReadData1);
    else n_pass++;
    @(negedge clk);
    // Unknown write index with the enable low must leave every register intact.
    bus.RegWrite      = 1'b0;
    bus.WriteRegister = 5'bxxxxx;
    bus.WriteData     = {$urandom, $urandom};
    tick();
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, '0, 5'(i), 5'(i));
      #1;
      n_checks++;
      if (bus.ReadData1 !== exp_read(5'(i)))
        $display("FAIL disabled_sweep idx=%0d: got %h expected %h", i, bus.ReadData1, exp_read(5'(i)));
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_hazard();
    logic [DW-1:0] want;
    drive(1'b1, 5'd9, 64'h1, 5'd0, 5'd0);
    tick();
    drive(1'b1, 5'd9, 64'h2, 5'd9, 5'd9);
    #1;
`ifdef REGFILE_BYPASS_EN
    want = 64'h2;
`else
    want = 64'h1;
`endif
    n_checks++;
    if (bus.ReadData1 !== want) $display("FAIL hazard_rd1_now: got %h expected %h", bus.ReadData1, want);
    else n_pass++;
    n_checks++;
    if (bus.ReadData2 !== want) $display("FAIL hazard_rd2_now: got %h expected %h", bus.ReadData2, want);
    else n_pass++;
    tick();
    drive(1'b0, 5'd0, '0, 5'd9, 5'd9);
    #1;
    n_checks++;
    if (bus.ReadData1 !== 64'h2) $display("FAIL hazard_rd1_next: got %h expected 2", bus.ReadData1);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_priority();
    drive(1'b1, 5'd5, 64'h0123_4567_89AB_CDEF, 5'd0, 5'd0);
    tick();
    rst_n = 1'b0;
    drive(1'b1, 5'd3, 64'h55, 5'd3, 5'd5);
    tick();
    rst_n = 1'b1;
    drive(1'b0, 5'd0, '0, 5'd3, 5'd5);
    #1;
    n_checks++;
    if (bus.ReadData1 !== 64'h0) $display("FAIL rstprio_x3: got %h expected 0", bus.ReadData1);
    else n_pass++;
    n_checks++;
    if (bus.ReadData2 !== 64'h0) $display("FAIL rstprio_x5: got %h expected 0", bus.ReadData2);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [4:0] wr;
    logic [4:0] r1;
    logic [4:0] r2;
    for (int c = 0; c < 400; c++) begin
      wr = 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 4) == 0) ? r1 : 5'($urandom_range(0, 31));
      rst_n = ($urandom_range(0, 59) != 0);
      drive(1'($urandom_range(0, 2) != 0), wr, {$urandom, $urandom}, r1, r2);
      #1;
      n_checks++;
      if (bus.ReadData1 !== exp_read(r1))
        $display("FAIL random_rd1 cyc=%0d idx=%0d: got %h expected %h", c, r1, bus.ReadData1, exp_read(r1));
      else n_pass++;
      n_checks++;
      if (bus.ReadData2 !== exp_read(r2))
        $display("FAIL random_rd2 cyc=%0d idx=%0d: got %h expected %h", c, r2, bus.ReadData2, exp_read(r2));
      else n_pass++;
      tick();
    end
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, '0, 5'(i), 5'(31 - i));
      #1;
      n_checks++;
      if (bus.ReadData1 !== exp_read(5'(i)))
        $display("FAIL final_sweep idx=%0d: got %h expected %h", i, bus.ReadData1, exp_read(5'(i)));
      else n_pass++;
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 5'd0, '0, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) model[i] = '0;
    @(negedge clk);
    test_reset();
    test_write_readback();
    test_zero_reg();
    test_write_disabled();
    test_hazard();
    test_reset_priority();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameter: DATA_W, default 64, width of each architectural register and of the read/write data buses.
REQ-002 Parameter: ZERO_REG, default 31, index of the hardwired-zero register (XZR).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset is synchronous and active-low; it is sampled on the rising edge of clk, and 0 means reset is asserted.
REQ-005 RegWrite  input  1  write enable for the write port.
REQ-006 WriteRegister  input  5  destination register index.
REQ-007 WriteData  input  DATA_W  data to store.
REQ-008 ReadRegister1  input  5  read port 1 index.
REQ-009 ReadRegister2  input  5  read port 2 index.
REQ-010 ReadData1  output  DATA_W  contents of the register selected by ReadRegister1.
REQ-011 ReadData2  output  DATA_W  contents of the register selected by ReadRegister2.

Function
REQ-012 The block SHALL hold 32 registers of DATA_W bits each.
REQ-013 Writes SHALL take effect at the rising edge of clk when RegWrite=1, reset=1 and WriteRegister!=ZERO_REG.
REQ-014 A write SHALL update only the register selected by the one-hot decode of WriteRegister; all other registers hold.
REQ-015 Writes to ZERO_REG SHALL be discarded.
REQ-016 The ZERO_REG storage SHALL read as all-zeros at all times.
REQ-017 Read ports SHALL be combinational, with zero-cycle latency from ReadRegisterN to ReadDataN.
REQ-018 Each read port SHALL be built as a DATA_W-wide bank of 32:1 bit-slice selects, with slice b choosing bit b from the 32 registers.
REQ-019 Both read ports SHALL operate independently, including when ReadRegister1==ReadRegister2, where both ports return identical data.
REQ-020 Same-cycle read and write to the same index (non-zero) SHALL return the old value on ReadDataN, with the new value visible from the next cycle, unless REGFILE_BYPASS_EN is defined.
REQ-021 When RegWrite=0, no register SHALL change, regardless of WriteRegister and WriteData.
REQ-022 X/unknown on WriteRegister while RegWrite=0 SHALL NOT corrupt state.

Reset
REQ-023 When reset=0 at a rising clk edge, all 32 registers SHALL clear to 0.
REQ-024 After reset, ReadData1 and ReadData2 SHALL read 0 for every index.
REQ-025 Reset SHALL dominate RegWrite: a write coincident with asserted reset is lost.
REQ-026 Reset asserted mid-program SHALL clear state on that edge, with no partial writes.

Configuration
REQ-027 Macro REGFILE_BYPASS_EN, when defined, SHALL make each read port return WriteData when RegWrite=1, reset=1, WriteRegister==ReadRegisterN and WriteRegister!=ZERO_REG (write-through for the WB->ID hazard).
REQ-028 With REGFILE_BYPASS_EN undefined, no bypass logic SHALL be present, and reads see the stored value only.
REQ-029 Bypass SHALL never forward for ZERO_REG, and ReadDataN stays 0 for that index.

Structure
REQ-030 A shared package regfile_pkg SHALL hold NUM_REGS=32, REG_IDX_W=5, the default DATA_W=64 and ZERO_REG=31 constants, and the reg_idx_t typedef.
REQ-031 The write-enable decode SHALL be a sub-module decoder5_32: 5-bit index plus enable in, 32-bit one-hot out.
REQ-032 The read-side bit-slice selects SHALL reuse the existing 32:1 single-bit select cell per bit per port; no behavioural array indexing SHALL be used on the read path.

Verification
REQ-033 Reset: hold reset=0 for 1 edge, then sweep ReadRegister1/2 over 0..31 -> all reads = 0.
REQ-034 Write/read-back: write X5=64'h0123_4567_89AB_CDEF, X30=64'hFFFF_FFFF_FFFF_FFFF, then read ReadRegister1=5 and ReadRegister2=30 -> exact values; X4 and X6 remain 0.
REQ-035 Zero register: write X31=64'hDEAD_BEEF with RegWrite=1 -> ReadData1 for index 31 = 0 on the following and all later cycles.
REQ-036 Write disabled: RegWrite=0, WriteRegister=7, WriteData=64'hA5A5 -> X7 unchanged (0).
REQ-037 Same-cycle hazard: X9 holds 64'h1, then write X9=64'h2 while reading 9 -> ReadData1=64'h1 that cycle (64'h2 with REGFILE_BYPASS_EN), and 64'h2 the next cycle in both builds.
REQ-038 Reset priority: reset=0 with RegWrite=1, WriteRegister=3, WriteData=64'h55 -> X3 = 0 after the edge, and X5 previously written is also cleared.
